valve_sequencer: RTL and testbench

//   Sits between the raw tank level sensors, the water_level FSM and the valve drivers.

---
 rtl/valve_sequencer_if.sv | 13 +
 rtl/valve_sequencer.sv | 126 ++++++++++++
 tb/tb_valve_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/valve_sequencer_if.sv
// Signal bundle between the level sensors / water_level FSM and the valve sequencer.
interface valve_sequencer_if;
  logic [3:1] s_raw;
  logic [3:1] s_db;
  logic [3:0] req;
  logic [3:0] valve;
  logic       fault;
  logic       fault_clr;
  logic       busy;

  modport master (output s_raw, req, fault_clr, input s_db, valve, fault, busy);
  modport slave  (input s_raw, req, fault_clr, output s_db, valve, fault, busy);
endinterface

// File: rtl/valve_sequencer.sv
// Debounces the tank level sensors, checks their consistency and paces valve openings
// so that at most one valve opens per GAP_CYCLES window; closes take effect at once.
module valve_sequencer #(
  parameter int DEB_CYCLES = 16,
  parameter int GAP_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  valve_sequencer_if.slave bus
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {RUN, GAP, FAULT} state_t;

  logic [3:1]    sync_p0, sync_p1, s_db_r;
  logic [DW-1:0] deb_cnt [3:1];

  state_t        state, state_n;
  logic [3:0]    valve_r, valve_n;
  logic          fault_r, fault_n;
  logic          busy_r, busy_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic          invalid;
  logic [3:0]    tgt, pending, first;

  // Stage p0/p1: two-flop synchroniser, then per-bit run-length debounce
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      s_db_r  <= '0;
      for (int i = 1; i <= 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync_p0 <= bus.s_raw;
      sync_p1 <= sync_p0;
      for (int i = 1; i <= 3; i++) begin
        if (sync_p1[i] != s_db_r[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            s_db_r[i]  <= ~s_db_r[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Levels must fill bottom-up: a higher sensor wet above a dry lower one is a fault
  assign invalid = (s_db_r[3] & ~s_db_r[2]) | (s_db_r[2] & ~s_db_r[1]);
  assign tgt     = bus.req & {4{~fault_r}};
  assign pending = tgt & ~valve_r;
  assign first   = pending & (~pending + 4'd1);

  // Stage p2: sequencer state and registered valve/fault/busy outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RUN;
      valve_r <= '0;
      fault_r <= 1'b0;
      busy_r  <= 1'b0;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      valve_r <= valve_n;
      fault_r <= fault_n;
      busy_r  <= busy_n;
      gap_cnt <= gap_n;
    end
  end

  always_comb begin
    state_n = state;
    valve_n = valve_r & tgt;
    fault_n = fault_r;
    gap_n   = gap_cnt;
    unique case (state)
      RUN: begin
        if (invalid) begin
          state_n = FAULT;
          fault_n = 1'b1;
          valve_n = '0;
          gap_n   = '0;
        end else if (pending != 4'd0) begin
          valve_n = valve_n | first;
          gap_n   = GAP_LOAD;
          if (GAP_CYCLES > 1) state_n = GAP;
        end
      end
      GAP: begin
        if (invalid) begin
          state_n = FAULT;
          fault_n = 1'b1;
          valve_n = '0;
          gap_n   = '0;
        end else begin
          gap_n = gap_cnt - 1'b1;
          if (gap_cnt == GW'(1)) state_n = RUN;
        end
      end
      FAULT: begin
        valve_n = '0;
        gap_n   = '0;
        fault_n = 1'b1;
        if (bus.fault_clr && !invalid) begin
          state_n = RUN;
          fault_n = 1'b0;
        end
      end
      default: state_n = RUN;
    endcase
    busy_n = ~fault_n & (|(bus.req & ~valve_n));
  end

  assign bus.s_db  = s_db_r;
  assign bus.valve = valve_r;
  assign bus.fault = fault_r;
  assign bus.busy  = busy_r;

endmodule

// File: tb/tb_valve_sequencer.sv
// Bench for valve_sequencer: directed stimulus pushes timed expectations into a
// scoreboard queue, a negedge monitor retires them against the DUT outputs.
module tb_valve_sequencer;

  localparam int V = 0, SDB = 1, FLT = 2, BSY = 3, V1 = 4;

  typedef struct {
    int         cyc;
    int         sel;
    logic [3:0] val;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   done = 1'b0;
  exp_t sbq[$];

  valve_sequencer_if bus ();
  valve_sequencer_if bus1 ();

  valve_sequencer #(.DEB_CYCLES(16), .GAP_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  valve_sequencer #(.DEB_CYCLES(2), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int c, input int sel, input logic [3:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.sel  = sel;
    e.val  = v;
    e.name = nm;
    sbq.push_back(e);
  endtask

  function automatic logic [3:0] actual(input int sel);
    case (sel)
      V:       return bus.valve;
      SDB:     return {1'b0, bus.s_db};
      FLT:     return {3'b000, bus.fault};
      BSY:     return {3'b000, bus.busy};
      default: return bus1.valve;
    endcase
  endfunction

  // Monitor: retire every expectation due this cycle; late ones count as misses
  always @(negedge clk) begin
    logic [3:0] act;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc <= cyc) begin
        act = actual(sbq[i].sel);
        n_vec++;
        if (sbq[i].cyc < cyc || act !== sbq[i].val) begin
          n_err++;
          $display("FAIL %s (cycle %0d): got %b, expected %b", sbq[i].name, cyc, act, sbq[i].val);
        end
        sbq.delete(i);
      end
    end
    if (done) begin
      foreach (sbq[i]) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: never checked, expected %b at cycle %0d", sbq[i].name, sbq[i].val, sbq[i].cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  initial begin
    int t;
    reset_n        = 1'b0;
    bus.s_raw      = '0;
    bus.req        = '0;
    bus.fault_clr  = 1'b0;
    bus1.s_raw     = '0;
    bus1.req       = '0;
    bus1.fault_clr = 1'b0;

    step(2);
    expect_at(cyc, V,   4'b0000, "rst_valve");
    expect_at(cyc, SDB, 4'b0000, "rst_sdb");
    expect_at(cyc, FLT, 4'b0000, "rst_fault");
    expect_at(cyc, BSY, 4'b0000, "rst_busy");
    expect_at(cyc, V1,  4'b0000, "rst_valve1");
    reset_n = 1'b1;
    step(2);

    // Debounce: a 10-cycle glitch is rejected, a held level lands 18 cycles later
    t = cyc;
    bus.s_raw = 3'b001;
    expect_at(t + 12, SDB, 4'b0000, "glitch_a");
    expect_at(t + 19, SDB, 4'b0000, "glitch_b");
    step(10);
    bus.s_raw = 3'b000;
    step(10);
    t = cyc;
    bus.s_raw = 3'b001;
    expect_at(t + 17, SDB, 4'b0000, "deb_early");
    expect_at(t + 18, SDB, 4'b0001, "deb_edge");
    step(20);

    // Paced openings, fr1 first, 8 cycles apart
    t = cyc;
    bus.req = 4'b1111;
    expect_at(t,      BSY, 4'b0000, "busy_idle");
    expect_at(t + 1,  V,   4'b0001, "open_fr1");
    expect_at(t + 1,  BSY, 4'b0001, "busy_set");
    expect_at(t + 8,  V,   4'b0001, "hold_fr1");
    expect_at(t + 9,  V,   4'b0011, "open_fr2");
    expect_at(t + 16, V,   4'b0011, "hold_fr2");
    expect_at(t + 17, V,   4'b0111, "open_fr3");
    expect_at(t + 24, BSY, 4'b0001, "busy_hold");
    expect_at(t + 25, V,   4'b1111, "open_dfr");
    expect_at(t + 25, BSY, 4'b0000, "busy_drop");
    step(26);

    // Immediate close, then re-request mid-gap respects spacing
    t = cyc;
    expect_at(t, V, 4'b1111, "all_open");
    bus.req = 4'b0000;
    expect_at(t + 1,  V,   4'b0000, "close_all");
    expect_at(t + 6,  V,   4'b0000, "gap_hold");
    expect_at(t + 7,  V,   4'b0010, "reopen_fr2");
    expect_at(t + 14, V,   4'b0010, "gap_hold2");
    expect_at(t + 15, V,   4'b0110, "reopen_fr3");
    expect_at(t + 15, BSY, 4'b0000, "busy_done");
    step(1);
    bus.req = 4'b0110;
    step(15);

    // Inconsistent sensors force a sticky fault
    t = cyc;
    bus.s_raw = 3'b100;
    expect_at(t + 18, SDB, 4'b0100, "sdb_bad");
    expect_at(t + 18, V,   4'b0110, "pre_fault_valve");
    expect_at(t + 18, FLT, 4'b0000, "pre_fault");
    expect_at(t + 19, FLT, 4'b0001, "fault_set");
    expect_at(t + 19, V,   4'b0000, "fault_shut");
    expect_at(t + 19, BSY, 4'b0000, "fault_busy");
    expect_at(t + 23, FLT, 4'b0001, "clr_ignored");
    expect_at(t + 40, SDB, 4'b0100, "sdb_still_bad");
    expect_at(t + 41, SDB, 4'b0111, "sdb_good");
    expect_at(t + 41, FLT, 4'b0001, "fault_sticky");
    expect_at(t + 41, V,   4'b0000, "fault_valve");
    expect_at(t + 43, FLT, 4'b0000, "fault_clear");
    expect_at(t + 43, V,   4'b0000, "clear_valve");
    expect_at(t + 44, V,   4'b0001, "reopen_fr1");
    expect_at(t + 53, V,   4'b0011, "midgap_valves");
    step(18);
    bus.req = 4'b1111;
    step(3);
    bus.fault_clr = 1'b1;
    step(1);
    bus.fault_clr = 1'b0;
    step(1);
    bus.s_raw = 3'b111;
    step(19);
    bus.fault_clr = 1'b1;
    step(1);
    bus.fault_clr = 1'b0;
    step(11);

    // Asynchronous reset in the middle of a gap
    t = cyc;
    reset_n = 1'b0;
    expect_at(t,      V,   4'b0000, "arst_valve");
    expect_at(t,      SDB, 4'b0000, "arst_sdb");
    expect_at(t,      BSY, 4'b0000, "arst_busy");
    expect_at(t,      FLT, 4'b0000, "arst_fault");
    expect_at(t + 3,  V,   4'b0000, "post_rst_idle");
    expect_at(t + 4,  V,   4'b0001, "restart_fr1");
    expect_at(t + 11, V,   4'b0001, "restart_hold");
    expect_at(t + 12, V,   4'b0011, "restart_fr2");
    step(3);
    reset_n = 1'b1;
    step(10);

    // Single-cycle gap: one opening per cycle
    t = cyc;
    bus1.req = 4'b1111;
    expect_at(t + 1, V1, 4'b0001, "g1_fr1");
    expect_at(t + 2, V1, 4'b0011, "g1_fr2");
    expect_at(t + 3, V1, 4'b0111, "g1_fr3");
    expect_at(t + 4, V1, 4'b1111, "g1_dfr");
    expect_at(t + 6, V1, 4'b1110, "g1_close");
    step(5);
    bus1.req = 4'b1110;
    step(3);
    done = 1'b1;
  end

endmodule
